// File: rtl/updown_cmd_pkg.sv
// Shared types and default timing constants for the up/down command generator.
package updown_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DELAY   = 2'd1,
      REPEAT  = 2'd2,
      BLOCKED = 2'd3
   } state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_REPEAT_DELAY    = 50;
   localparam int DEF_REPEAT_PERIOD   = 10;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for one pushbutton.
module btn_debounce
   import updown_cmd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic level_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The level flips on the cycle the count would reach DEBOUNCE_CYCLES.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/updown_cmd_gen.sv
// Turns two bouncy pushbuttons into one-cycle up/down commands with auto-repeat.
module updown_cmd_gen
   import updown_cmd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_up_raw,
   input  logic btn_down_raw,
   input  logic repeat_en,
   output logic up,
   output logic down,
   output logic busy
);

   localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

   logic lvl_up, lvl_dn;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (btn_up_raw),
      .level_o (lvl_up)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (btn_down_raw),
      .level_o (lvl_dn)
   );

   state_e        state_q, state_d;
   logic          held_up_q, held_up_d;
   logic [RW-1:0] cnt_q, cnt_d;
   logic          up_q, up_d, down_q, down_d, busy_q;
   logic          up_r_q, dn_r_q, up_p_q, dn_p_q;
   logic          rise_up, rise_dn, held_lvl, other_rise;
   logic [RW-1:0] cnt_last;

   assign rise_up    = up_r_q & ~up_p_q;
   assign rise_dn    = dn_r_q & ~dn_p_q;
   assign held_lvl   = held_up_q ? up_r_q : dn_r_q;
   assign other_rise = held_up_q ? rise_dn : rise_up;
   assign cnt_last   = (state_q == DELAY) ? DLY_LAST : PER_LAST;

   // Second-button rise outranks release, which outranks a due repeat pulse.
   always_comb begin
      state_d   = state_q;
      held_up_d = held_up_q;
      cnt_d     = cnt_q;
      up_d      = 1'b0;
      down_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise_up || rise_dn) begin
               if (up_r_q && dn_r_q) begin
                  state_d = BLOCKED;
               end else begin
                  state_d   = DELAY;
                  held_up_d = rise_up;
                  up_d      = rise_up;
                  down_d    = rise_dn;
                  cnt_d     = '0;
               end
            end
         end
         DELAY, REPEAT: begin
            if (other_rise) begin
               state_d = BLOCKED;
            end else if (!held_lvl) begin
               state_d = IDLE;
            end else if (repeat_en) begin
               if (cnt_q == cnt_last) begin
                  state_d = REPEAT;
                  cnt_d   = '0;
                  up_d    = held_up_q;
                  down_d  = ~held_up_q;
               end else begin
                  cnt_d = cnt_q + RW'(1);
               end
            end
         end
         BLOCKED: begin
            if (!up_r_q && !dn_r_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         held_up_q <= 1'b0;
         cnt_q     <= '0;
         up_q      <= 1'b0;
         down_q    <= 1'b0;
         busy_q    <= 1'b0;
         up_r_q    <= 1'b0;
         dn_r_q    <= 1'b0;
         up_p_q    <= 1'b0;
         dn_p_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         held_up_q <= held_up_d;
         cnt_q     <= cnt_d;
         up_q      <= up_d;
         down_q    <= down_d;
         busy_q    <= lvl_up | lvl_dn;
         up_r_q    <= lvl_up;
         dn_r_q    <= lvl_dn;
         up_p_q    <= up_r_q;
         dn_p_q    <= dn_r_q;
      end
   end

   assign up   = up_q;
   assign down = down_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_updown_cmd_gen.sv
// Directed bench for updown_cmd_gen with hand-computed pulse edges and busy windows.
module tb_updown_cmd_gen;

   logic clk;
   logic rst_n;
   logic btn_up_raw;
   logic btn_down_raw;
   logic repeat_en;
   logic up;
   logic down;
   logic busy;

   int checks   = 0;
   int failures = 0;

   // Expected behaviour of the current run, edges numbered from the run start.
   int up_edges[$];
   int dn_edges[$];
   int busy_lo[$];
   int busy_hi[$];

   updown_cmd_gen #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (8),
      .REPEAT_PERIOD   (3)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_up_raw   (btn_up_raw),
      .btn_down_raw (btn_down_raw),
      .repeat_en    (repeat_en),
      .up           (up),
      .down         (down),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic exp_up(input int e);
      foreach (up_edges[i]) if (up_edges[i] == e) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic exp_dn(input int e);
      foreach (dn_edges[i]) if (dn_edges[i] == e) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic exp_busy(input int e);
      foreach (busy_lo[i]) if (e >= busy_lo[i] && e <= busy_hi[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic clear_exp();
      up_edges.delete();
      dn_edges.delete();
      busy_lo.delete();
      busy_hi.delete();
   endtask

   // Input levels to be sampled at edge e of scenario sc.
   task automatic drive(input int sc, input int e);
      btn_up_raw   = 1'b0;
      btn_down_raw = 1'b0;
      repeat_en    = 1'b1;
      case (sc)
         1: btn_up_raw = (e <= 4);
         2: btn_down_raw = (e < 20) ? (((e / 2) % 2) == 0) : (e <= 26);
         3: btn_up_raw = (e <= 29);
         4: begin
            btn_up_raw   = (e <= 30) || (e >= 45 && e <= 51);
            btn_down_raw = (e >= 13 && e <= 30);
         end
         5: begin
            btn_up_raw = (e <= 20);
            repeat_en  = !(e >= 9 && e <= 13);
         end
         6: btn_up_raw = 1'b1;
         7: btn_up_raw = (e <= 6);
         default: ;
      endcase
   endtask

   task automatic run(input int sc, input int n);
      for (int e = 0; e < n; e++) begin
         drive(sc, e);
         @(posedge clk);
         #1;
         chk($sformatf("s%0d_up_e%0d", sc, e), up, exp_up(e));
         chk($sformatf("s%0d_down_e%0d", sc, e), down, exp_dn(e));
         chk($sformatf("s%0d_busy_e%0d", sc, e), busy, exp_busy(e));
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      btn_up_raw   = 1'b0;
      btn_down_raw = 1'b0;
      repeat_en    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_up", up, 1'b0);
      chk("reset_down", down, 1'b0);
      chk("reset_busy", busy, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Clean press held 5 cycles: one up pulse, no repeat.
      clear_exp();
      up_edges.push_back(7);
      busy_lo.push_back(6); busy_hi.push_back(10);
      run(1, 20);

      // Bouncing down button, then stable from edge 20.
      clear_exp();
      dn_edges.push_back(27);
      busy_lo.push_back(26); busy_hi.push_back(32);
      run(2, 40);

      // Long hold with auto-repeat.
      clear_exp();
      up_edges = '{7, 15, 18, 21, 24, 27, 30, 33, 36};
      busy_lo.push_back(6); busy_hi.push_back(35);
      run(3, 45);

      // Second button during REPEAT blocks; a fresh press afterwards works.
      clear_exp();
      up_edges = '{7, 15, 18, 52};
      busy_lo.push_back(6);  busy_hi.push_back(36);
      busy_lo.push_back(51); busy_hi.push_back(57);
      run(4, 65);

      // repeat_en low for 5 cycles in DELAY shifts the first repeat by 5.
      clear_exp();
      up_edges = '{7, 20, 23, 26};
      busy_lo.push_back(6); busy_hi.push_back(26);
      run(5, 35);

      // Reset while REPEAT is pulsing, with the button still held.
      clear_exp();
      up_edges = '{7, 15, 18};
      busy_lo.push_back(6); busy_hi.push_back(1000);
      run(6, 19);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_up", up, 1'b0);
      chk("rst_mid_down", down, 1'b0);
      chk("rst_mid_busy", busy, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("rst_hold_up_%0d", i), up, 1'b0);
         chk($sformatf("rst_hold_down_%0d", i), down, 1'b0);
         chk($sformatf("rst_hold_busy_%0d", i), busy, 1'b0);
      end
      rst_n = 1'b1;
      clear_exp();
      up_edges.push_back(7);
      busy_lo.push_back(6); busy_hi.push_back(12);
      run(7, 16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/updown_cmd_gen.md
UPDOWN_CMD_GEN -- requirements
Module: updown_cmd_gen

Interface
REQ-001 Parameters, one per line (name, default, meaning); each SHALL be legal at any value satisfying REQ-008:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles before a debounced level changes.
- REPEAT_DELAY, 50: hold cycles from the first pulse to the first auto-repeat pulse.
- REPEAT_PERIOD, 10: cycles between subsequent auto-repeat pulses.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- btn_up_raw  input  1  raw up pushbutton, asynchronous, bouncy.
- btn_down_raw  input  1  raw down pushbutton, asynchronous, bouncy.
- repeat_en  input  1  auto-repeat enable, synchronous.
- up  output  1  one-cycle increment command to the downstream counter.
- down  output  1  one-cycle decrement command to the downstream counter.
- busy  output  1  high while either debounced button is held.
REQ-003 up, down and busy SHALL be driven directly from flops.

Function
REQ-004 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-005 Debounce, per button:
- When the synchronized value differs from the debounced level, a counter SHALL increment once per cycle.
- When the counter reaches DEBOUNCE_CYCLES, the debounced level SHALL toggle and the counter SHALL clear.
- Any cycle in which the synchronized value equals the debounced level SHALL clear the counter.
REQ-006 FSM states and transitions:
- IDLE: exactly one debounced level rises -> emit one pulse on the matching output, go to DELAY.
- DELAY: after REPEAT_DELAY cycles with repeat_en=1 -> emit one pulse, go to REPEAT.
- REPEAT: emit one pulse every REPEAT_PERIOD cycles.
- BLOCKED: both debounced levels high -> no pulses; go to IDLE only when both levels are low.
- From DELAY or REPEAT: the held button's level falls -> IDLE.
REQ-007 Timing, pulse rules and edge cases:
- Latency: a clean raw rising edge sampled at edge 0 SHALL produce its pulse at edge 2+DEBOUNCE_CYCLES+1.
- up and down SHALL never be high in the same cycle; every pulse SHALL be exactly one cycle wide.
- Both levels rise in the same cycle: go to BLOCKED, no pulse.
- The second button rises during DELAY or REPEAT: go to BLOCKED immediately and cancel the pending pulse.
- repeat_en=0 in DELAY or REPEAT: the repeat counter SHALL hold, with no pulses until repeat_en returns to 1.
- busy SHALL equal the OR of the debounced levels, registered.
REQ-008 Parameter limits: DEBOUNCE_CYCLES>=1, REPEAT_DELAY>=2, REPEAT_PERIOD>=2. Counter widths SHALL be $clog2(value+1), and no counter SHALL wrap.

Reset
REQ-009 rst_n low SHALL, asynchronously:
- clear all synchronizer flops, debounced levels and counters;
- set the FSM to IDLE;
- drive up=0, down=0, busy=0.
REQ-010 A button still held on reset release SHALL produce one pulse after the normal REQ-007 latency, not earlier.
REQ-011 Reset asserted mid-DELAY or mid-REPEAT SHALL drop any pending pulse, with no glitch on up or down.

Structure
REQ-012 Package updown_cmd_pkg SHALL hold the FSM state enum typedef (IDLE, DELAY, REPEAT, BLOCKED) and the default parameter constants.
REQ-013 Sub-module btn_debounce (synchronizer plus debounce counter, parameter DEBOUNCE_CYCLES) SHALL be instantiated twice. The FSM and repeat counter SHALL live in updown_cmd_gen.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-014 Directed scenarios:
- Clean press of btn_up_raw, held 5 cycles -> single up pulse at edge 7, down stays 0, busy high from edge 6.
- btn_down_raw toggling every 2 cycles for 20 cycles, then stable high -> no pulse during bounce, then one down pulse 7 edges after it stabilises.
- btn_up_raw held 30 cycles, repeat_en=1 -> up pulses at edges 7, 15, 18, 21, ... until release.
- btn_up_raw held, btn_down_raw pressed during REPEAT -> no further pulses; after both are released, a fresh up press pulses normally.
- Hold with repeat_en dropped to 0 for 5 cycles during DELAY -> the first repeat pulse shifts 5 cycles later.
- rst_n pulsed low during REPEAT -> up, down and busy read 0 immediately and stay 0 through reset; with the button still held, one pulse arrives 7 edges after release.
